// File: rtl/jtframe_ddr_pkg.sv
// Shared encodings and widths for the two-client DDR3 read arbiter.
package jtframe_ddr_pkg;

  localparam int unsigned DDR_DW = 64;
  localparam int unsigned WDOG_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/jtframe_ddr_rd_arb_if.sv
// Avalon read-port bundle between the arbiter (master) and the DDR3 controller (slave).
interface jtframe_ddr_rd_arb_if #(
  parameter int unsigned AW  = 29,
  parameter int unsigned BCW = 8
);
  import jtframe_ddr_pkg::*;

  logic              ddram_busy;
  logic              ddram_rd;
  logic [AW-1:0]     ddram_addr;
  logic [BCW-1:0]    ddram_burstcnt;
  logic [DDR_DW-1:0] ddram_dout;
  logic              ddram_dout_ready;

  modport master (
    input  ddram_busy, ddram_dout, ddram_dout_ready,
    output ddram_rd, ddram_addr, ddram_burstcnt
  );

  modport slave (
    output ddram_busy, ddram_dout, ddram_dout_ready,
    input  ddram_rd, ddram_addr, ddram_burstcnt
  );

endinterface

// File: rtl/jtframe_ddr_rd_arb.sv
// Two-client round-robin burst arbiter for the DDR3 Avalon read port.
// Define JTFRAME_DDR_ARB_WATCHDOG_EN to add a WAIT watchdog and the sticky error output.
module jtframe_ddr_rd_arb
  import jtframe_ddr_pkg::*;
#(
  parameter int unsigned AW  = 29,
  parameter int unsigned BCW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [AW-1:0]     addr0,
  input  logic [BCW-1:0]    burstcnt0,
  output logic              dout_ready0,
  output logic              done0,
  input  logic              req1,
  input  logic [AW-1:0]     addr1,
  input  logic [BCW-1:0]    burstcnt1,
  output logic              dout_ready1,
  output logic              done1,
  output logic [DDR_DW-1:0] dout,
  output logic              owner,
  output logic              busy,
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
  output logic              error,
`endif
  jtframe_ddr_rd_arb_if.master ddr
);

  state_t         state, state_nx;
  logic           owner_nx;
  logic           last, last_nx;
  logic           rd, rd_nx;
  logic [AW-1:0]  addr_q, addr_nx;
  logic [BCW-1:0] bcnt_q, bcnt_nx;
  logic [BCW-1:0] cnt, cnt_nx;
  logic [1:0]     done_q, done_nx;
  logic           zero_pend, zero_nx;
  logic [1:0]     req_m;
  logic           pick;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog, wdog_nx;
  logic              err_q, err_nx;
`endif

  // A client whose done is showing cannot win again on that edge
  assign req_m = {req1 & ~done_q[1], req0 & ~done_q[0]};
  assign pick  = (&req_m) ? ~last : req_m[1];

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    rd_nx    = rd;
    addr_nx  = addr_q;
    bcnt_nx  = bcnt_q;
    cnt_nx   = cnt;
    done_nx  = 2'b00;
    zero_nx  = 1'b0;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
    wdog_nx  = wdog;
    err_nx   = err_q;
`endif
    unique case (state)
      ST_IDLE: begin
        if (zero_pend) begin
          done_nx[owner] = 1'b1;
        end else if (|req_m) begin
          owner_nx = pick;
          last_nx  = pick;
          addr_nx  = pick ? addr1 : addr0;
          bcnt_nx  = pick ? burstcnt1 : burstcnt0;
          // Zero-length bursts complete without touching the DDR3 port
          if (bcnt_nx != '0) begin
            state_nx = ST_ISSUE;
            rd_nx    = 1'b1;
          end else begin
            zero_nx  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!ddr.ddram_busy) begin
          rd_nx    = 1'b0;
          cnt_nx   = bcnt_q;
          state_nx = ST_WAIT;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
          wdog_nx  = '0;
`endif
        end
      end
      ST_WAIT: begin
        if (ddr.ddram_dout_ready) begin
          cnt_nx = cnt - BCW'(1);
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
          wdog_nx = '0;
`endif
          if (cnt == BCW'(1)) begin
            done_nx[owner] = 1'b1;
            state_nx       = ST_IDLE;
          end
        end
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
        else begin
          wdog_nx = wdog + WDOG_W'(1);
          if (&wdog_nx) begin
            done_nx[owner] = 1'b1;
            err_nx         = 1'b1;
            state_nx       = ST_IDLE;
          end
        end
`endif
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      rd        <= 1'b0;
      addr_q    <= '0;
      bcnt_q    <= '0;
      cnt       <= '0;
      done_q    <= 2'b00;
      zero_pend <= 1'b0;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
      wdog      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      last      <= last_nx;
      rd        <= rd_nx;
      addr_q    <= addr_nx;
      bcnt_q    <= bcnt_nx;
      cnt       <= cnt_nx;
      done_q    <= done_nx;
      zero_pend <= zero_nx;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
      wdog      <= wdog_nx;
      err_q     <= err_nx;
`endif
    end
  end

  // Beats are forwarded only to the owner and only while a burst is in flight
  assign dout_ready0 = (state == ST_WAIT) & ~owner & ddr.ddram_dout_ready;
  assign dout_ready1 = (state == ST_WAIT) &  owner & ddr.ddram_dout_ready;
  assign dout        = ddr.ddram_dout;
  assign done0       = done_q[0];
  assign done1       = done_q[1];
  assign busy        = (state != ST_IDLE);

  assign ddr.ddram_rd       = rd;
  assign ddr.ddram_addr     = addr_q;
  assign ddr.ddram_burstcnt = bcnt_q;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
  assign error = err_q;
`endif

endmodule

// File: tb/tb_jtframe_ddr_rd_arb.sv
// Bench for jtframe_ddr_rd_arb: randomized DDR3 responder plus job-level round-robin reference.
// Honours JTFRAME_DDR_ARB_WATCHDOG_EN the same way as the design.
module tb_jtframe_ddr_rd_arb;
  import jtframe_ddr_pkg::*;

  localparam int unsigned AW  = 29;
  localparam int unsigned BCW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1;
  logic [AW-1:0]     addr0, addr1;
  logic [BCW-1:0]    burstcnt0, burstcnt1;
  logic              dout_ready0, dout_ready1, done0, done1;
  logic [DDR_DW-1:0] dout;
  logic              owner, busy;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
  logic              error;
`endif

  jtframe_ddr_rd_arb_if #(.AW(AW), .BCW(BCW)) ddr ();

  jtframe_ddr_rd_arb #(.AW(AW), .BCW(BCW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .burstcnt0(burstcnt0), .dout_ready0(dout_ready0), .done0(done0),
    .req1(req1), .addr1(addr1), .burstcnt1(burstcnt1), .dout_ready1(dout_ready1), .done1(done1),
    .dout(dout), .owner(owner), .busy(busy),
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
    .error(error),
`endif
    .ddr(ddr)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // DDR3 responder state and logs
  int            cyc = 0;
  int            beats_left = 0;
  int            beat_idx = 0;
  int            last_beat_cyc = 0;
  logic [AW-1:0] cur_addr = '0;
  int            stall_left = 0;
  bit            rnd_busy = 1'b0;
  int            limit = 0;
  bit            stray_mode = 1'b0;
  int            stray_sent = 0;
  int            beats_rx[2];
  logic [AW-1:0] cmd_addr_q[$];
  int            cmd_bcnt_q[$];
  bit            done_q[$];

  function automatic logic [63:0] beat_data(input logic [AW-1:0] a, input int i);
    return {a, 3'b000, 32'(i)};
  endfunction

  task automatic clear_logs();
    beats_rx   = '{0, 0};
    stray_sent = 0;
    cmd_addr_q.delete();
    cmd_bcnt_q.delete();
    done_q.delete();
  endtask

  initial begin : ddr_model
    bit            drv, drv_stray, c;
    logic [63:0]   data;
    logic [AW-1:0] beat_addr;
    ddr.ddram_busy       = 1'b0;
    ddr.ddram_dout       = '0;
    ddr.ddram_dout_ready = 1'b0;
    beats_rx = '{0, 0};
    forever begin
      @(negedge clk);
      cyc++;
      drv       = (beats_left > 0) && ($urandom_range(0, 2) != 0);
      drv_stray = stray_mode;
      beat_addr = cur_addr;
      data      = beat_data(cur_addr, beat_idx);
      ddr.ddram_dout_ready = drv;
      ddr.ddram_dout       = drv ? data : {$urandom, $urandom};
      if (drv) begin
        beats_left--;
        beat_idx++;
        last_beat_cyc = cyc;
      end
      if (ddr.ddram_rd && stall_left > 0) begin
        ddr.ddram_busy = 1'b1;
        stall_left--;
      end else begin
        ddr.ddram_busy = ddr.ddram_rd && rnd_busy && ($urandom_range(0, 1) == 1);
      end
      // Command accepted on the coming edge
      if (ddr.ddram_rd && !ddr.ddram_busy) begin
        cmd_addr_q.push_back(ddr.ddram_addr);
        cmd_bcnt_q.push_back(int'(ddr.ddram_burstcnt));
        cur_addr   = ddr.ddram_addr;
        beat_idx   = 0;
        beats_left = (limit > 0 && limit < int'(ddr.ddram_burstcnt)) ? limit : int'(ddr.ddram_burstcnt);
      end
      #1;
      if (drv) begin
        if (drv_stray) begin
          stray_sent++;
          chk("stray_dropped", 64'({dout_ready1, dout_ready0}), 64'd0);
        end else begin
          c = beat_addr[AW-1];
          chk("beat_route", 64'({dout_ready1, dout_ready0}), c ? 64'd2 : 64'd1);
          chk("beat_data", dout, data);
          chk("beat_owner", 64'(owner), 64'(c));
          beats_rx[c]++;
        end
      end
      if (done0 || done1) begin
        chk("done_busy_low", 64'(busy), 64'd0);
        done_q.push_back(done1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_done(input bit c, input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(c ? done1 : done0) && n < bound);
    chk(c ? "done1_seen" : "done0_seen", 64'(c ? done1 : done0), 64'd1);
  endtask

  // Job lists per client; each client holds req while it has jobs left
  int            n_jobs[2];
  logic [AW-1:0] job_addr[2][8];
  int            job_bcnt[2][8];

  task automatic run_jobs(input bit last_in, input string tag, output bit last_out);
    bit            exp_o[$];
    logic [AW-1:0] exp_a[$];
    int            exp_b[$];
    int            exp_beats[2];
    int            p[2];
    int            dones;
    bit            l;
    bit            w;
    // Reference: free client wins, ties go to the client that did not win last
    exp_beats = '{0, 0};
    p = '{0, 0};
    l = last_in;
    while (p[0] < n_jobs[0] || p[1] < n_jobs[1]) begin
      if (p[0] < n_jobs[0] && p[1] < n_jobs[1]) w = ~l;
      else w = (p[1] < n_jobs[1]);
      exp_o.push_back(w);
      if (job_bcnt[w][p[w]] != 0) begin
        exp_a.push_back(job_addr[w][p[w]]);
        exp_b.push_back(job_bcnt[w][p[w]]);
        exp_beats[w] += job_bcnt[w][p[w]];
      end
      p[w]++;
      l = w;
    end
    last_out = l;

    clear_logs();
    p = '{0, 0};
    req0 = (n_jobs[0] > 0);
    req1 = (n_jobs[1] > 0);
    addr0 = job_addr[0][0]; burstcnt0 = BCW'(job_bcnt[0][0]);
    addr1 = job_addr[1][0]; burstcnt1 = BCW'(job_bcnt[1][0]);
    dones = 0;
    for (int i = 0; i < 4000 && dones < n_jobs[0] + n_jobs[1]; i++) begin
      step();
      if (done0) begin
        dones++; p[0]++;
        if (p[0] < n_jobs[0]) begin addr0 = job_addr[0][p[0]]; burstcnt0 = BCW'(job_bcnt[0][p[0]]); end
        else req0 = 1'b0;
      end
      if (done1) begin
        dones++; p[1]++;
        if (p[1] < n_jobs[1]) begin addr1 = job_addr[1][p[1]]; burstcnt1 = BCW'(job_bcnt[1][p[1]]); end
        else req1 = 1'b0;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk({tag, "_done_count"}, 64'(done_q.size()), 64'(exp_o.size()));
    for (int i = 0; i < exp_o.size() && i < done_q.size(); i++)
      chk({tag, "_grant_order"}, 64'(done_q[i]), 64'(exp_o[i]));
    chk({tag, "_cmd_count"}, 64'(cmd_addr_q.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < cmd_addr_q.size(); i++) begin
      chk({tag, "_cmd_addr"}, 64'(cmd_addr_q[i]), 64'(exp_a[i]));
      chk({tag, "_cmd_bcnt"}, 64'(cmd_bcnt_q[i]), 64'(exp_b[i]));
    end
    chk({tag, "_beats0"}, 64'(beats_rx[0]), 64'(exp_beats[0]));
    chk({tag, "_beats1"}, 64'(beats_rx[1]), 64'(exp_beats[1]));
  endtask

  initial begin : watchdog_timer
    #2000000;
    $display("FAIL sim_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int rd_cycles, addr_bad;
    bit rd_seen, seen, l;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0; burstcnt0 = '0; burstcnt1 = '0;
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd", 64'(ddr.ddram_rd), 64'd0);
    chk("rst_done", 64'({done1, done0}), 64'd0);
    chk("rst_owner", 64'(owner), 64'd0);
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
    chk("rst_error", 64'(error), 64'd0);
`endif
    rst = 1'b0;
    step();

    // Single client, four beats
    clear_logs();
    req0 = 1'b1; addr0 = 29'h0C00_0000; burstcnt0 = 8'd4;
    step();
    chk("s1_rd", 64'(ddr.ddram_rd), 64'd1);
    chk("s1_addr", 64'(ddr.ddram_addr), 64'h0C00_0000);
    chk("s1_bcnt", 64'(ddr.ddram_burstcnt), 64'd4);
    chk("s1_busy", 64'(busy), 64'd1);
    chk("s1_owner", 64'(owner), 64'd0);
    wait_done(1'b0, 100);
    req0 = 1'b0;
    chk("s1_busy_at_done", 64'(busy), 64'd0);
    step();
    chk("s1_done_pulse", 64'(done0), 64'd0);
    chk("s1_beats0", 64'(beats_rx[0]), 64'd4);
    chk("s1_beats1", 64'(beats_rx[1]), 64'd0);
    chk("s1_cmds", 64'(cmd_addr_q.size()), 64'd1);

    // Busy stall: five busy cycles hold the command for six
    step();
    clear_logs();
    stall_left = 5;
    req1 = 1'b1; addr1 = 29'h1012_3450; burstcnt1 = 8'd3;
    rd_cycles = 0; addr_bad = 0;
    for (int i = 0; i < 60 && !done1; i++) begin
      step();
      if (ddr.ddram_rd) begin
        rd_cycles++;
        if (ddr.ddram_addr !== addr1) addr_bad++;
      end
    end
    req1 = 1'b0;
    chk("s2_done", 64'(done1), 64'd1);
    chk("s2_rd_cycles", 64'(rd_cycles), 64'd6);
    chk("s2_addr_stable", 64'(addr_bad), 64'd0);
    chk("s2_cmds", 64'(cmd_addr_q.size()), 64'd1);
    chk("s2_beats1", 64'(beats_rx[1]), 64'd3);

    // Contention: both held, two bursts each of two beats
    step();
    n_jobs = '{2, 2};
    for (int k = 0; k < 2; k++) begin
      job_addr[0][k] = AW'(32'h0000_1000 + 32'(k) * 32'h40); job_bcnt[0][k] = 2;
      job_addr[1][k] = AW'(32'h1000_2000 + 32'(k) * 32'h40); job_bcnt[1][k] = 2;
    end
    run_jobs(1'b1, "cont", l);

    // Zero-length burst on client 1
    step();
    clear_logs();
    req1 = 1'b1; addr1 = 29'h1000_0040; burstcnt1 = 8'd0;
    step();
    rd_seen = ddr.ddram_rd;
    chk("z_done_early", 64'(done1), 64'd0);
    step();
    rd_seen |= ddr.ddram_rd;
    chk("z_done", 64'(done1), 64'd1);
    req1 = 1'b0;
    step();
    rd_seen |= ddr.ddram_rd;
    chk("z_done_pulse", 64'(done1), 64'd0);
    chk("z_no_rd", 64'(rd_seen), 64'd0);
    chk("z_busy", 64'(busy), 64'd0);

    // Reset after the first of eight beats
    step();
    clear_logs();
    req0 = 1'b1; addr0 = 29'h00AB_C000; burstcnt0 = 8'd8;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = dout_ready0;
    end
    chk("rm_first_beat", 64'(seen), 64'd1);
    rst = 1'b1; stray_mode = 1'b1; req0 = 1'b0;
    step();
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_rd", 64'(ddr.ddram_rd), 64'd0);
    chk("rm_done", 64'({done1, done0}), 64'd0);
    chk("rm_owner", 64'(owner), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 100 && beats_left > 0; i++) step();
    chk("rm_stray_sent", 64'(stray_sent), 64'd7);
    stray_mode = 1'b0;
    step();
    clear_logs();
    req0 = 1'b1; addr0 = 29'h00AB_D000; burstcnt0 = 8'd5;
    wait_done(1'b0, 200);
    req0 = 1'b0;
    chk("rm_after_beats0", 64'(beats_rx[0]), 64'd5);
    chk("rm_after_cmds", 64'(cmd_addr_q.size()), 64'd1);

    // Only two of four beats ever arrive
    step();
    clear_logs();
    limit = 2;
    req0 = 1'b1; addr0 = 29'h0000_0800; burstcnt0 = 8'd4;
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
    wait_done(1'b0, 1300);
    // last beat sampled on edge last_beat_cyc, done rises on edge cyc-1
    chk("wd_delay", 64'(cyc - 1 - last_beat_cyc), 64'd1023);
    chk("wd_error", 64'(error), 64'd1);
    chk("wd_busy", 64'(busy), 64'd0);
    chk("wd_beats0", 64'(beats_rx[0]), 64'd2);
    req0 = 1'b0;
`else
    repeat (1100) step();
    chk("wd_stuck_busy", 64'(busy), 64'd1);
    chk("wd_no_done", 64'(done_q.size()), 64'd0);
    chk("wd_beats0", 64'(beats_rx[0]), 64'd2);
    req0 = 1'b0;
`endif
    limit = 0;
    do_reset(2);
    step();
`ifdef JTFRAME_DDR_ARB_WATCHDOG_EN
    chk("wd_error_cleared", 64'(error), 64'd0);
`endif

    // Randomized job mixes with random waitrequest
    rnd_busy = 1'b1;
    l = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        n_jobs[c] = int'($urandom_range(2, 6));
        for (int k = 0; k < 8; k++) begin
          job_addr[c][k] = {c[0], 28'($urandom)};
          job_bcnt[c][k] = int'($urandom_range(0, 5));
        end
      end
      run_jobs(l, "rnd", l);
      step();
    end
    rnd_busy = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/jtframe_ddr_rd_arb.md
Name: jtframe_ddr_rd_arb

Overview:
- Two-client read arbiter for the MiSTer DDR3 Avalon read port.
- Sits between the DDR3 port and two burst readers, e.g. the ROM dump engine (client 0) and a secondary streamer such as a sample or NVRAM reader (client 1).
- Serialises whole bursts with round-robin fairness.
- Routes returned beats only to the owning client, so neither client needs DDR3 busy or ownership logic.

Parameters:
- AW, 29, DDR3 word-address width.
- BCW, 8, burst-count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req0  in  1  client 0 burst request; held until done0.
- addr0  in  AW  client 0 burst start address; sampled at grant.
- burstcnt0  in  BCW  client 0 beats requested; sampled at grant.
- dout_ready0  out  1  client 0 data strobe (qualified ddram_dout_ready).
- done0  out  1  one-cycle pulse after client 0's last beat.
- req1, addr1, burstcnt1, dout_ready1, done1  same, client 1.
- dout  out  64  ddram_dout passed through combinationally to both clients.
- owner  out  1  index of the client holding the port (valid while busy).
- busy  out  1  high outside IDLE.
- ddram_busy  in  1  Avalon waitrequest.
- ddram_rd  out  1  read command.
- ddram_addr  out  AW  latched burst address.
- ddram_burstcnt  out  BCW  latched burst count.
- ddram_dout  in  64  read data.
- ddram_dout_ready  in  1  read data valid.
- error  out  1  sticky watchdog flag; exists only with the optional feature.

Behaviour:
- Reset (synchronous, rst high at clk edge): state=IDLE; outputs ddram_rd, done0/1, busy, owner, error are 0; last=1, so client 0 wins the first tie. Reset mid-burst abandons the burst; beats arriving afterwards are ignored while in IDLE.
- IDLE:
  - No request: nothing happens.
  - One request: that client wins.
  - Both requesting: the client that is not `last` wins.
  - On a win: latch addr/burstcnt into ddram_addr/ddram_burstcnt, set owner, set last=owner.
  - Latched burstcnt≠0: go to ISSUE, so ddram_rd rises 1 cycle after req is seen.
  - Latched burstcnt==0: pulse done<owner> next cycle and return to IDLE without touching DDR3.
- ISSUE:
  - ddram_rd=1, with address and count held stable.
  - The command is accepted on the first cycle with ddram_busy==0.
  - On acceptance: ddram_rd=0 next cycle, beat counter=ddram_burstcnt, go to WAIT.
  - req dropping in ISSUE is ignored; the burst completes.
- WAIT:
  - dout_ready<owner> = ddram_dout_ready, combinational, zero latency.
  - The other client's dout_ready stays 0.
  - Each strobe decrements the counter.
  - On the strobe where the counter==1: next cycle done<owner>=1 for one cycle and state=IDLE.
  - ddram_busy is ignored in WAIT.
  - Any ddram_dout_ready in IDLE/ISSUE is dropped and not forwarded.
- Arbitration:
  - Occurs only in IDLE, which is at least 1 cycle between bursts.
  - A client re-asserting req in the cycle after its own done loses to a waiting peer.
- Arithmetic: counter is BCW bits and never wraps, because 0 is filtered before WAIT.
- busy = state≠IDLE.

Optional Feature:
- Macro: JTFRAME_DDR_ARB_WATCHDOG_EN.
- When defined:
  - A 10-bit counter clears on every accepted command and every beat, and increments in WAIT.
  - On reaching 1023: pulse done<owner>, set sticky error, return to IDLE.
  - error clears only on rst.
- When undefined:
  - WAIT lasts until all beats arrive.
  - The error port is absent.

Decomposition:
- Package jtframe_ddr_pkg holds:
  - state encodings ST_IDLE, ST_ISSUE, ST_WAIT (2-bit);
  - DDR_DW=64;
  - WDOG_W=10.
- No sub-module. The round-robin pick is a 3-line expression and stays inline.

Test Plan:
- Single client: req0, addr0=0x0C000000, burstcnt0=4, ddram_busy=0 → ddram_rd high 1 cycle later with that address and count.
  - Four beats appear on dout_ready0 only.
  - done0 pulses once; busy falls the same cycle.
- Busy stall: ddram_busy=1 for 5 cycles in ISSUE → ddram_rd stays high for 6 cycles with stable address; exactly one command accepted.
- Contention: req0 and req1 asserted together and held, each burstcnt=2 → grants alternate 0,1,0,1 over 4 bursts.
  - owner matches each burst; no beat is mis-routed.
- Zero length: burstcnt1=0 → done1 pulses 2 cycles after req1; ddram_rd never asserted.
- Reset mid-burst: rst asserted after 1 of 8 beats → outputs reset next edge.
  - The remaining 7 stray beats produce no dout_ready.
  - A following req0 burst completes normally.
- Watchdog (macro defined): burstcnt0=4, only 2 beats delivered → done0 and error asserted 1023 cycles after the last beat.
  - Macro undefined: the arbiter stays in WAIT.
